// File: rtl/rs_alu_station_pkg.sv
// ALU reservation station shared types.
// Entry layout, widths and CDB tag matcher.
package rs_pkg;
  localparam int RS_DEPTH_DFLT    = 8;
  localparam int OP_W             = 5;
  localparam int PHYSICAL_REG_NUM = 64;
  localparam int PREG_W           = 6;
  localparam int NUM_CDB          = 2;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [PREG_W-1:0] src1;
    logic [PREG_W-1:0] src2;
    logic [PREG_W-1:0] dst;
    logic              rdy1;
    logic              rdy2;
  } rs_alu_entry_t;

  function automatic logic cdb_match(
    input logic [PREG_W-1:0]              tag,
    input logic [NUM_CDB-1:0]             cdb_valid,
    input logic [NUM_CDB-1:0][PREG_W-1:0] cdb_reg_addr
  );
    logic m;
    m = 1'b0;
    for (int k = 0; k < NUM_CDB; k++)
      m = m | (cdb_valid[k] &
               (cdb_reg_addr[k] == tag));
    return m;
  endfunction
endpackage

// File: rtl/rs_alu_station_if.sv
// Dispatch, wakeup and issue bundle.
// master = producer/consumer side, slave = station.
interface rs_alu_station_if
  import rs_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DFLT
);
  localparam int CNT_W = $clog2(RS_DEPTH) + 1;

  logic                             dispatch_valid;
  logic                             dispatch_ready;
  logic [OP_W-1:0]                  dispatch_op;
  logic [PREG_W-1:0]                dispatch_src1;
  logic [PREG_W-1:0]                dispatch_src2;
  logic [PREG_W-1:0]                dispatch_dst;
  logic [PHYSICAL_REG_NUM-1:0]      reg_status;
  logic [NUM_CDB-1:0]               cdb_valid;
  logic [NUM_CDB-1:0][PREG_W-1:0]   cdb_reg_addr;
  logic                             issue_valid;
  logic                             issue_ready;
  logic [OP_W-1:0]                  issue_op;
  logic [PREG_W-1:0]                issue_src1;
  logic [PREG_W-1:0]                issue_src2;
  logic [PREG_W-1:0]                issue_dst;
  logic [CNT_W-1:0]                 occupancy;

  modport master (
    output dispatch_valid, dispatch_op,
    output dispatch_src1, dispatch_src2,
    output dispatch_dst, reg_status,
    output cdb_valid, cdb_reg_addr,
    output issue_ready,
    input  dispatch_ready, issue_valid,
    input  issue_op, issue_src1,
    input  issue_src2, issue_dst,
    input  occupancy
  );

  modport slave (
    input  dispatch_valid, dispatch_op,
    input  dispatch_src1, dispatch_src2,
    input  dispatch_dst, reg_status,
    input  cdb_valid, cdb_reg_addr,
    input  issue_ready,
    output dispatch_ready, issue_valid,
    output issue_op, issue_src1,
    output issue_src2, issue_dst,
    output occupancy
  );
endinterface

// File: rtl/rs_alu_station_age_select.sv
// Age matrix: r_age[i][j] means entry i older than j.
// Picks the oldest eligible entry as a one-hot.
module rs_age_select #(
  parameter int RS_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [RS_DEPTH-1:0] i_valid,
  input  logic [RS_DEPTH-1:0] i_alloc,
  input  logic [RS_DEPTH-1:0] i_free,
  input  logic [RS_DEPTH-1:0] i_elig,
  output logic [RS_DEPTH-1:0] o_sel,
  output logic                o_any
);
  logic [RS_DEPTH-1:0] r_age [RS_DEPTH];

  // New entry is younger than every surviving entry
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RS_DEPTH; i++)
        r_age[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++)
        for (int j = 0; j < RS_DEPTH; j++)
          if (i_alloc[i])
            r_age[i][j] <= 1'b0;
          else if (i_alloc[j] && i_valid[i] &&
                   !i_free[i])
            r_age[i][j] <= 1'b1;
          else if (i_free[j])
            r_age[i][j] <= 1'b0;
    end
  end

  // Eligible entry with no older eligible entry wins
  always_comb begin
    o_sel = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      logic blk;
      blk = 1'b0;
      for (int j = 0; j < RS_DEPTH; j++)
        blk = blk | (i_elig[j] & r_age[j][i]);
      o_sel[i] = i_elig[i] & !blk;
    end
  end

  assign o_any = |i_elig;
endmodule

// File: rtl/rs_alu_station.sv
// ALU reservation station with CDB wakeup.
// Oldest-ready select into a registered issue port.
module rs_alu_station
  import rs_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DFLT
) (
  input  logic         clk,
  input  logic         reset,
  rs_alu_station_if.slave bus
);
  localparam int CNT_W = $clog2(RS_DEPTH) + 1;

  rs_alu_entry_t       r_rs [RS_DEPTH];
  logic [CNT_W-1:0]    r_occ;
  logic                r_iv;
  logic [OP_W-1:0]     r_iop;
  logic [PREG_W-1:0]   r_is1;
  logic [PREG_W-1:0]   r_is2;
  logic [PREG_W-1:0]   r_idst;

  logic [RS_DEPTH-1:0] w_valid;
  logic [RS_DEPTH-1:0] w_m1;
  logic [RS_DEPTH-1:0] w_m2;
  logic [RS_DEPTH-1:0] w_elig;
  logic [RS_DEPTH-1:0] w_sel;
  logic [RS_DEPTH-1:0] w_alloc;
  logic [RS_DEPTH-1:0] w_free;
  logic                w_any;
  logic                w_load;
  logic                w_fire;
  logic                w_dready;
  rs_alu_entry_t       w_pick;
  rs_alu_entry_t       w_new;

  assign w_dready = (r_occ < CNT_W'(RS_DEPTH));
  assign w_fire   = bus.dispatch_valid & w_dready;
  assign w_load   = (!r_iv | bus.issue_ready) & w_any;
  assign w_free   = w_load ? w_sel : '0;

  // Per-entry CDB match and eligibility
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_valid[i] = r_rs[i].valid;
      w_m1[i] = cdb_match(r_rs[i].src1,
        bus.cdb_valid, bus.cdb_reg_addr);
      w_m2[i] = cdb_match(r_rs[i].src2,
        bus.cdb_valid, bus.cdb_reg_addr);
      w_elig[i] = r_rs[i].valid &
        (r_rs[i].rdy1 | w_m1[i]) &
        (r_rs[i].rdy2 | w_m2[i]);
    end
  end

  // Lowest free slot takes the dispatch
  always_comb begin
    logic found;
    found   = 1'b0;
    w_alloc = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (!w_valid[i] && !found) begin
        w_alloc[i] = w_fire;
        found      = 1'b1;
      end
  end

  // Incoming entry with status/CDB bypass
  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.op    = bus.dispatch_op;
    w_new.src1  = bus.dispatch_src1;
    w_new.src2  = bus.dispatch_src2;
    w_new.dst   = bus.dispatch_dst;
    w_new.rdy1  =
      bus.reg_status[bus.dispatch_src1] |
      cdb_match(bus.dispatch_src1,
        bus.cdb_valid, bus.cdb_reg_addr);
    w_new.rdy2  =
      bus.reg_status[bus.dispatch_src2] |
      cdb_match(bus.dispatch_src2,
        bus.cdb_valid, bus.cdb_reg_addr);
  end

  // One-hot mux of the selected entry
  always_comb begin
    w_pick = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (w_sel[i]) w_pick = r_rs[i];
  end

  rs_age_select #(.RS_DEPTH(RS_DEPTH)) u_age (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_valid),
    .i_alloc (w_alloc),
    .i_free  (w_free),
    .i_elig  (w_elig),
    .o_sel   (w_sel),
    .o_any   (w_any)
  );

  // Entry allocate, free and sticky wakeup
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RS_DEPTH; i++)
        r_rs[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++)
        if (w_alloc[i])
          r_rs[i] <= w_new;
        else if (w_free[i])
          r_rs[i].valid <= 1'b0;
        else if (r_rs[i].valid) begin
          r_rs[i].rdy1 <= r_rs[i].rdy1 | w_m1[i];
          r_rs[i].rdy2 <= r_rs[i].rdy2 | w_m2[i];
        end
    end
  end

  // Occupancy counts entries, not the issue reg
  always_ff @(posedge clk) begin
    if (!reset)
      r_occ <= '0;
    else
      r_occ <= r_occ + CNT_W'(w_fire)
                     - CNT_W'(w_load);
  end

  // Issue register, held under backpressure
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_iv   <= 1'b0;
      r_iop  <= '0;
      r_is1  <= '0;
      r_is2  <= '0;
      r_idst <= '0;
    end else if (w_load) begin
      r_iv   <= 1'b1;
      r_iop  <= w_pick.op;
      r_is1  <= w_pick.src1;
      r_is2  <= w_pick.src2;
      r_idst <= w_pick.dst;
    end else if (bus.issue_ready) begin
      r_iv   <= 1'b0;
    end
  end

  assign bus.dispatch_ready = w_dready;
  assign bus.issue_valid    = r_iv;
  assign bus.issue_op       = r_iop;
  assign bus.issue_src1     = r_is1;
  assign bus.issue_src2     = r_is2;
  assign bus.issue_dst      = r_idst;
  assign bus.occupancy      = r_occ;
endmodule

// File: tb/tb_rs_alu_station.sv
// Bench for rs_alu_station: queue model
// in dispatch order plus literal checks.
module tb_rs_alu_station;
  import rs_pkg::*;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rs_alu_station_if #(.RS_DEPTH(DEPTH)) bus ();

  rs_alu_station #(.RS_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [PREG_W-1:0] s1;
    logic [PREG_W-1:0] s2;
    logic [PREG_W-1:0] d;
    bit                r1;
    bit                r2;
  } ment_t;

  ment_t             m_q [$];
  bit                m_iv;
  logic [OP_W-1:0]   m_op;
  logic [PREG_W-1:0] m_s1, m_s2, m_d;
  int                got [$];
  int                total = 0;
  int                bad = 0;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h",
               n, a, e);
    end
  endtask

  function automatic bit cm(
    input logic [PREG_W-1:0] t);
    bit m = 0;
    for (int k = 0; k < NUM_CDB; k++)
      if (bus.cdb_valid[k] &&
          bus.cdb_reg_addr[k] == t) m = 1;
    return m;
  endfunction

  task automatic step_model();
    ment_t e;
    int    k;
    bit    rd;
    if (!reset) begin
      m_q.delete();
      m_iv = 0; m_op = 0;
      m_s1 = 0; m_s2 = 0; m_d = 0;
      return;
    end
    rd = (m_q.size() < DEPTH);
    k = -1;
    foreach (m_q[i])
      if (k < 0 &&
          (m_q[i].r1 || cm(m_q[i].s1)) &&
          (m_q[i].r2 || cm(m_q[i].s2)))
        k = i;
    if ((!m_iv || bus.issue_ready) && k >= 0)
    begin
      m_iv = 1;
      m_op = m_q[k].op;
      m_s1 = m_q[k].s1;
      m_s2 = m_q[k].s2;
      m_d  = m_q[k].d;
      m_q.delete(k);
    end else if (bus.issue_ready) begin
      m_iv = 0;
    end
    foreach (m_q[i]) begin
      m_q[i].r1 = m_q[i].r1 || cm(m_q[i].s1);
      m_q[i].r2 = m_q[i].r2 || cm(m_q[i].s2);
    end
    if (bus.dispatch_valid && rd) begin
      e.op = bus.dispatch_op;
      e.s1 = bus.dispatch_src1;
      e.s2 = bus.dispatch_src2;
      e.d  = bus.dispatch_dst;
      e.r1 = bus.reg_status[e.s1] || cm(e.s1);
      e.r2 = bus.reg_status[e.s2] || cm(e.s2);
      m_q.push_back(e);
    end
  endtask

  task automatic compare_all();
    chk("dready", 32'(bus.dispatch_ready),
        32'(m_q.size() < DEPTH));
    chk("occ", 32'(bus.occupancy),
        32'(m_q.size()));
    chk("iv", 32'(bus.issue_valid), 32'(m_iv));
    chk("iop", 32'(bus.issue_op), 32'(m_op));
    chk("is1", 32'(bus.issue_src1), 32'(m_s1));
    chk("is2", 32'(bus.issue_src2), 32'(m_s2));
    chk("idst", 32'(bus.issue_dst), 32'(m_d));
  endtask

  task automatic tick();
    step_model();
    if (bus.issue_valid && bus.issue_ready)
      got.push_back(int'(bus.issue_dst));
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic put(input int op, input int s1,
                     input int s2, input int d);
    bus.dispatch_valid = 1'b1;
    bus.dispatch_op    = OP_W'(op);
    bus.dispatch_src1  = PREG_W'(s1);
    bus.dispatch_src2  = PREG_W'(s2);
    bus.dispatch_dst   = PREG_W'(d);
  endtask

  task automatic idle();
    bus.dispatch_valid = 1'b0;
  endtask

  task automatic cdb(input int lane,
                     input int tag);
    bus.cdb_valid = '0;
    if (lane >= 0) begin
      bus.cdb_valid[lane]    = 1'b1;
      bus.cdb_reg_addr[lane] = PREG_W'(tag);
    end
  endtask

  initial begin
    reset              = 1'b0;
    bus.dispatch_valid = 1'b0;
    bus.dispatch_op    = '0;
    bus.dispatch_src1  = '0;
    bus.dispatch_src2  = '0;
    bus.dispatch_dst   = '0;
    bus.reg_status     = '1;
    bus.cdb_valid      = '0;
    bus.cdb_reg_addr   = '0;
    bus.issue_ready    = 1'b1;
    #2;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rst_iv", 32'(bus.issue_valid), 0);
    chk("rst_occ", 32'(bus.occupancy), 0);
    chk("rst_dr", 32'(bus.dispatch_ready), 1);
    chk("rst_op", 32'(bus.issue_op), 0);

    // basic ready dispatch
    put(3, 5, 6, 20); tick();
    idle(); tick();
    chk("t1_iv", 32'(bus.issue_valid), 1);
    chk("t1_op", 32'(bus.issue_op), 3);
    chk("t1_s1", 32'(bus.issue_src1), 5);
    chk("t1_s2", 32'(bus.issue_src2), 6);
    chk("t1_dst", 32'(bus.issue_dst), 20);
    chk("t1_occ", 32'(bus.occupancy), 0);
    tick();

    // CDB wakeup, later and same-cycle
    bus.reg_status[7] = 1'b0;
    put(4, 7, 6, 21); tick();
    idle(); tick();
    chk("t2_wait", 32'(bus.issue_valid), 0);
    cdb(0, 7); tick();
    chk("t2_iv", 32'(bus.issue_valid), 1);
    chk("t2_s1", 32'(bus.issue_src1), 7);
    cdb(-1, 0); tick();
    put(5, 7, 6, 22); cdb(1, 7); tick();
    cdb(-1, 0); idle(); tick();
    chk("t2b_iv", 32'(bus.issue_valid), 1);
    chk("t2b_dst", 32'(bus.issue_dst), 22);
    tick();

    // fill under backpressure
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      put(1, 1, 2, 30 + i); tick();
      if (i == 7)
        chk("t3_occ7", 32'(bus.occupancy), 7);
      if (i == 8) begin
        chk("t3_occ8", 32'(bus.occupancy), 8);
        chk("t3_full",
            32'(bus.dispatch_ready), 0);
      end
      if (i == 9)
        chk("t3_drop", 32'(bus.occupancy), 8);
    end
    chk("t3_head", 32'(bus.issue_dst), 30);
    idle(); bus.issue_ready = 1'b1; tick();
    chk("t3_dr", 32'(bus.dispatch_ready), 1);
    chk("t3_occ", 32'(bus.occupancy), 7);
    chk("t3_next", 32'(bus.issue_dst), 31);
    for (int i = 0; i < 10; i++) tick();

    // oldest-first ordering, late wake
    bus.reg_status[9] = 1'b0;
    got.delete();
    put(2, 9, 1, 40); tick();
    put(2, 1, 2, 41); tick();
    put(2, 1, 2, 42); tick();
    idle(); tick();
    cdb(0, 9); tick();
    cdb(-1, 0); tick(); tick();
    chk("t4a_n", 32'(got.size()), 3);
    if (got.size() == 3) begin
      chk("t4a_0", 32'(got[0]), 41);
      chk("t4a_1", 32'(got[1]), 42);
      chk("t4a_2", 32'(got[2]), 40);
    end

    // oldest-first ordering, early wake
    got.delete();
    put(2, 9, 1, 43); tick();
    put(2, 1, 2, 44); cdb(1, 9); tick();
    cdb(-1, 0);
    put(2, 1, 2, 45); tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    chk("t4b_n", 32'(got.size()), 3);
    if (got.size() == 3) begin
      chk("t4b_0", 32'(got[0]), 43);
      chk("t4b_1", 32'(got[1]), 44);
      chk("t4b_2", 32'(got[2]), 45);
    end

    // hold under backpressure
    bus.issue_ready = 1'b0;
    put(6, 1, 2, 50); tick();
    put(6, 1, 2, 51); tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_iv", 32'(bus.issue_valid), 1);
      chk("t5_dst", 32'(bus.issue_dst), 50);
      chk("t5_occ", 32'(bus.occupancy), 1);
    end
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // mid-run reset discards everything
    bus.issue_ready = 1'b0;
    put(1, 1, 2, 55); tick();
    put(1, 1, 2, 56); tick();
    put(1, 1, 2, 57); tick();
    idle(); reset = 1'b0; tick();
    reset = 1'b1;
    chk("t6_iv", 32'(bus.issue_valid), 0);
    chk("t6_occ", 32'(bus.occupancy), 0);
    chk("t6_dr", 32'(bus.dispatch_ready), 1);
    bus.issue_ready = 1'b1;
    cdb(0, 11); tick();
    cdb(-1, 0);
    bus.reg_status[11] = 1'b0;
    put(7, 11, 1, 60); tick();
    idle(); tick(); tick();
    chk("t6_nowake", 32'(bus.issue_valid), 0);
    chk("t6_pend", 32'(bus.occupancy), 1);
    cdb(1, 11); tick();
    cdb(-1, 0);
    chk("t6_wake", 32'(bus.issue_dst), 60);
    tick(); tick();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
